// File: rtl/mult_div_unit.sv
// ============================================================================
//  Module      : mult_div_unit
//  Description : E-stage multiply/divide unit with architectural HI/LO.
//                Each op resolves in a fixed number of busy cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  mdOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mdRes
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             accept;
   logic             commit;

   logic [31:0] pend_hi;
   logic [31:0] pend_lo;
   logic        pend_wr;

   logic        is_md_op;
   logic        is_div;
   logic        mul_signed;
   logic        div_signed;
   logic        div_zero;
   logic [63:0] mul_a;
   logic [63:0] mul_b;
   logic [63:0] product;
   logic        neg_a;
   logic        neg_b;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [31:0] divisor;
   logic [31:0] uquot;
   logic [31:0] urem;
   logic [31:0] quot;
   logic [31:0] rem;
   logic        mthi_wr;
   logic        mtlo_wr;

   // ------------------------------------------------------------------------
   // Operation decode
   // ------------------------------------------------------------------------
   assign is_md_op   = (mdOp == OP_MULT) || (mdOp == OP_MULTU) ||
                       (mdOp == OP_DIV)  || (mdOp == OP_DIVU);
   assign is_div     = (mdOp == OP_DIV)  || (mdOp == OP_DIVU);
   assign mul_signed = (mdOp == OP_MULT);
   assign div_signed = (mdOp == OP_DIV);
   assign div_zero   = (B == 32'd0);

   assign mthi_wr = (state == S_IDLE) && !start && (mdOp == OP_MTHI);
   assign mtlo_wr = (state == S_IDLE) && !start && (mdOp == OP_MTLO);

   // ------------------------------------------------------------------------
   // Multiplier: 64-bit product of the (optionally sign-extended) operands
   // ------------------------------------------------------------------------
   assign mul_a   = {{32{mul_signed & A[31]}}, A};
   assign mul_b   = {{32{mul_signed & B[31]}}, B};
   assign product = mul_a * mul_b;

   // ------------------------------------------------------------------------
   // Divider: magnitude divide then restore signs, which makes the
   // 0x80000000 / -1 case fall out naturally as 0x80000000 remainder 0.
   // ------------------------------------------------------------------------
   assign neg_a   = div_signed & A[31];
   assign neg_b   = div_signed & B[31];
   assign abs_a   = neg_a ? (32'd0 - A) : A;
   assign abs_b   = neg_b ? (32'd0 - B) : B;
   assign divisor = div_zero ? 32'd1 : abs_b;
   assign uquot   = abs_a / divisor;
   assign urem    = abs_a % divisor;
   assign quot    = (neg_a ^ neg_b) ? (32'd0 - uquot) : uquot;
   assign rem     = neg_a ? (32'd0 - urem) : urem;

   // ------------------------------------------------------------------------
   // Occupancy FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= CNT_ZERO;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      commit    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && is_md_op) begin
               accept    = 1'b1;
               cnt_nxt   = is_div ? DIV_LOAD : MULT_LOAD;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            cnt_nxt = cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
               commit    = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = CNT_ZERO;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Pending result and architectural HI/LO
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_wr <= 1'b0;
         hi      <= 32'd0;
         lo      <= 32'd0;
      end else begin
         if (accept) begin
            // A zero divisor still occupies the unit but leaves HI/LO intact.
            pend_wr <= !(is_div && div_zero);
            if (is_div) begin
               pend_hi <= rem;
               pend_lo <= quot;
            end else begin
               pend_hi <= product[63:32];
               pend_lo <= product[31:0];
            end
         end
         if (commit && pend_wr) begin
            hi <= pend_hi;
            lo <= pend_lo;
         end else begin
            if (mthi_wr) begin
               hi <= A;
            end
            if (mtlo_wr) begin
               lo <= A;
            end
         end
      end
   end

   assign busy = (state == S_RUN);

   always_comb begin
      mdRes = 32'd0;
      case (mdOp)
         OP_MFHI: mdRes = hi;
         OP_MFLO: mdRes = lo;
         default: mdRes = 32'd0;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Self-checking bench for mult_div_unit against a timestamp model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  mdOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] mdRes;

   int checks = 0;
   int errors = 0;

   // reference model: architectural HI/LO plus the cycle at which the op lands
   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   bit          p_wr;
   int          cyc, done_at;
   int          bcount;

   mult_div_unit #(
      .MULT_CYCLES (MC),
      .DIV_CYCLES  (DC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .mdOp  (mdOp),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo),
      .mdRes (mdRes)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic model_compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sp, sa, sb, q, r;
      longint unsigned up;
      p_wr = 1'b1;
      case (op)
         4'd1: begin
            sp   = longint'($signed(a)) * longint'($signed(b));
            p_hi = sp[63:32];
            p_lo = sp[31:0];
         end
         4'd2: begin
            up   = {32'd0, a} * {32'd0, b};
            p_hi = up[63:32];
            p_lo = up[31:0];
         end
         4'd3: begin
            if (b == 32'd0) p_wr = 1'b0;
            else begin
               sa   = longint'($signed(a));
               sb   = longint'($signed(b));
               q    = sa / sb;
               r    = sa % sb;
               p_lo = q[31:0];
               p_hi = r[31:0];
            end
         end
         default: begin
            if (b == 32'd0) p_wr = 1'b0;
            else begin
               p_lo = a / b;
               p_hi = a % b;
            end
         end
      endcase
   endtask

   task automatic model_edge(input logic s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bit was_busy;
      was_busy = (cyc < done_at);
      cyc++;
      if (was_busy) begin
         if (cyc == done_at && p_wr) begin
            m_hi = p_hi;
            m_lo = p_lo;
         end
      end else if (s && op >= 4'd1 && op <= 4'd4) begin
         model_compute(op, a, b);
         done_at = cyc + ((op <= 4'd2) ? MC : DC);
      end else if (!s && op == 4'd7) begin
         m_hi = a;
      end else if (!s && op == 4'd8) begin
         m_lo = a;
      end
   endtask

   // One pipeline cycle: drive, check the combinational read, clock, check state.
   task automatic step(input logic s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] exp_res;
      start = s;
      mdOp  = op;
      A     = a;
      B     = b;
      #1;
      exp_res = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
      check_val("mdRes", mdRes, exp_res);
      @(posedge clk);
      model_edge(s, op, a, b);
      #1;
      check_val("busy", {31'd0, busy}, {31'd0, (cyc < done_at)});
      check_val("hi", hi, m_hi);
      check_val("lo", lo, m_lo);
      if (busy) bcount++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'd0, $urandom, $urandom);
   endtask

   task automatic reset_pulse();
      #2 reset = 1'b1;
      #1;
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_hi", hi, 32'd0);
      check_val("rst_lo", lo, 32'd0);
      m_hi    = 32'd0;
      m_lo    = 32'd0;
      done_at = cyc;
      #1 reset = 1'b0;
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [3:0] op;
      logic       s;
      reset = 1'b1;
      start = 1'b0;
      mdOp  = 4'd0;
      A     = 32'd0;
      B     = 32'd0;
      m_hi  = 32'd0;
      m_lo  = 32'd0;
      p_hi  = 32'd0;
      p_lo  = 32'd0;
      p_wr  = 1'b0;
      cyc   = 0;
      done_at = 0;
      repeat (2) @(posedge clk);
      #1;
      check_val("init_busy", {31'd0, busy}, 32'd0);
      check_val("init_hi", hi, 32'd0);
      check_val("init_lo", lo, 32'd0);
      reset = 1'b0;

      // signed multiply, busy exactly MC cycles
      bcount = 0;
      step(1'b1, 4'd1, 32'hFFFF_FFFE, 32'd3);
      idle(MC);
      check_val("t1_busy_cycles", bcount, MC);
      check_val("t1_hi", hi, 32'hFFFF_FFFF);
      check_val("t1_lo", lo, 32'hFFFF_FFFA);

      step(1'b1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      idle(MC);
      check_val("t2_hi", hi, 32'hFFFF_FFFE);
      check_val("t2_lo", lo, 32'h0000_0001);

      bcount = 0;
      step(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2);
      idle(DC);
      check_val("t3_busy_cycles", bcount, DC);
      check_val("t3_div_lo", lo, 32'hFFFF_FFFD);
      check_val("t3_div_hi", hi, 32'hFFFF_FFFF);
      step(1'b1, 4'd4, 32'hFFFF_FFF9, 32'd2);
      idle(DC);
      check_val("t3_divu_lo", lo, 32'h7FFF_FFFC);
      check_val("t3_divu_hi", hi, 32'h0000_0001);

      // divide by zero keeps preloaded HI/LO; overflow case
      step(1'b0, 4'd7, 32'h11, 32'd0);
      step(1'b0, 4'd8, 32'h22, 32'd0);
      bcount = 0;
      step(1'b1, 4'd3, 32'd5, 32'd0);
      idle(DC);
      check_val("t4_dz_busy_cycles", bcount, DC);
      check_val("t4_dz_hi", hi, 32'h11);
      check_val("t4_dz_lo", lo, 32'h22);
      step(1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      idle(DC);
      check_val("t4_ovf_lo", lo, 32'h8000_0000);
      check_val("t4_ovf_hi", hi, 32'h0);

      // activity while busy is ignored; mfhi shows stale HI
      step(1'b0, 4'd7, 32'h99, 32'd0);
      step(1'b1, 4'd1, 32'd3, 32'd4);
      step(1'b0, 4'd7, 32'h55, 32'd0);
      step(1'b1, 4'd3, 32'd100, 32'd7);
      start = 1'b0;
      mdOp  = 4'd5;
      #1;
      check_val("t5_stale_mfhi", mdRes, 32'h99);
      step(1'b0, 4'd5, 32'd0, 32'd0);
      step(1'b0, 4'd0, 32'd0, 32'd0);
      check_val("t5_still_busy", {31'd0, busy}, 32'd1);
      step(1'b0, 4'd0, 32'd0, 32'd0);
      check_val("t5_done", {31'd0, busy}, 32'd0);
      check_val("t5_hi", hi, 32'd0);
      check_val("t5_lo", lo, 32'd12);

      // async reset mid-divide, then a fresh multiply
      step(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2);
      idle(3);
      reset_pulse();
      step(1'b1, 4'd1, 32'd6, 32'd7);
      idle(MC);
      check_val("t6_lo", lo, 32'd42);
      check_val("t6_hi", hi, 32'd0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         op = 4'($urandom_range(0, 9));
         if ($urandom_range(0, 3) != 0) s = (op >= 4'd1 && op <= 4'd4);
         else                           s = 1'($urandom_range(0, 1));
         step(s, op, rnd_operand(), rnd_operand());
         if ($urandom_range(0, 99) == 0) reset_pulse();
      end
      idle(DC + 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
